// File: rtl/fp32_pkg.sv
// FP32 field layout and operand-class helpers shared by the FP add issue path.
package fp32_pkg;

  localparam int FP32_EXP_MSB = 30;
  localparam int FP32_EXP_LSB = 23;
  localparam int FP32_MAN_MSB = 22;
  localparam int FP32_MAN_LSB = 0;
  localparam logic [7:0] FP32_EXP_MAX = 8'hFF;

  localparam int FLAG_NAN  = 0;
  localparam int FLAG_INF  = 1;
  localparam int FLAG_ZERO = 2;

  function automatic logic is_nan(input logic [31:0] x);
    return (x[FP32_EXP_MSB:FP32_EXP_LSB] == FP32_EXP_MAX) &&
           (x[FP32_MAN_MSB:FP32_MAN_LSB] != '0);
  endfunction

  function automatic logic is_inf(input logic [31:0] x);
    return (x[FP32_EXP_MSB:FP32_EXP_LSB] == FP32_EXP_MAX) &&
           (x[FP32_MAN_MSB:FP32_MAN_LSB] == '0);
  endfunction

  // Denormals (exp==0, man!=0) deliberately do not count as zero.
  function automatic logic is_zero(input logic [31:0] x);
    return (x[FP32_EXP_MSB:FP32_EXP_LSB] == '0) &&
           (x[FP32_MAN_MSB:FP32_MAN_LSB] == '0);
  endfunction

endpackage

// File: rtl/fp_pair_fifo.sv
// Operand-pair FIFO: DEPTH x 64-bit storage with wrap-around pointers and occupancy count.
module fp_pair_fifo
  import fp32_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [63:0]              wr_data,
  output logic [63:0]              rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic [63:0]   mem_q [DEPTH];
  logic          do_push, do_pop;

  assign full    = (count_q == (PW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: stale entries are never visible while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/fp_add_issue_queue.sv
// Issue queue in front of a combinational FP32 adder: buffers operand pairs,
// drives the head pair to the adder and registers the sum with operand-class flags.
module fp_add_issue_queue
  import fp32_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  output logic [WIDTH-1:0]         add_a,
  output logic [WIDTH-1:0]         add_b,
  input  logic [WIDTH-1:0]         add_result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_result,
  output logic [2:0]               out_flags,
  output logic [$clog2(DEPTH):0]   count
);

  logic [2*WIDTH-1:0] head;
  logic               full, empty;
  logic               push, pop, slot_free;
  logic [2:0]         head_flags;

  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_result_q, out_result_d;
  logic [2:0]         out_flags_q, out_flags_d;

  assign in_ready  = ~full;
  assign push      = in_valid & in_ready;
  assign slot_free = ~out_valid_q | out_ready;
  assign pop       = ~empty & slot_free;

  fp_pair_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .wr_data ({in_a, in_b}),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  // Adder inputs are forced to zero while empty so no stale entry leaks out.
  assign add_a = empty ? '0 : head[2*WIDTH-1:WIDTH];
  assign add_b = empty ? '0 : head[WIDTH-1:0];

  always_comb begin
    head_flags            = '0;
    head_flags[FLAG_NAN]  = is_nan(add_a) | is_nan(add_b);
    head_flags[FLAG_INF]  = is_inf(add_a) | is_inf(add_b);
    head_flags[FLAG_ZERO] = is_zero(add_a) & is_zero(add_b);
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_flags_d  = out_flags_q;
    if (pop) begin
      out_valid_d  = 1'b1;
      out_result_d = add_result;
      out_flags_d  = head_flags;
    end else if (out_ready) begin
      out_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_flags_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_flags_q  <= out_flags_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_flags  = out_flags_q;

endmodule

// File: tb/tb_fp_add_issue_queue.sv
// Directed scoreboard bench for fp_add_issue_queue with a behavioural FP32 adder model on add_a/add_b.
module tb_fp_add_issue_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a, in_b;
  logic [31:0] add_a, add_b, add_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [2:0]  out_flags;
  logic [2:0]  count;

  logic [34:0] sb[$];
  logic [34:0] exp_cur;
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  fp_add_issue_queue #(.DEPTH(DEPTH), .WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_result (add_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags),
    .count      (count)
  );

  // Behavioural stand-in for FloatingAddition (exact for the directed operands used here).
  function automatic real fp2real(input logic [31:0] x);
    logic [10:0] e;
    logic [63:0] d;
    if (x[30:23] == 8'd0) return 0.0;
    e = {3'b000, x[30:23]} + 11'd896;
    d = {x[31], e, x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] real2fp(input real r);
    logic [63:0] d;
    logic [10:0] e;
    logic [10:0] e8w;
    d = $realtobits(r);
    e = d[62:52];
    if (e == 11'd0) return {d[63], 31'd0};
    e8w = e - 11'd896;
    return {d[63], e8w[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    if ((a[30:23] == 8'hFF && a[22:0] != 0) || (b[30:23] == 8'hFF && b[22:0] != 0))
      return 32'h7FC00000;
    if (a[30:23] == 8'hFF) return a;
    if (b[30:23] == 8'hFF) return b;
    return real2fp(fp2real(a) + fp2real(b));
  endfunction

  always_comb add_result = fp_add(add_a, add_b);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // One clock: record accepted input, compare any output the consumer takes, advance to next negedge.
  task automatic tick();
    logic [34:0] e;
    if (in_valid && in_ready) sb.push_back(exp_cur);
    if (out_valid && out_ready) begin
      checks++;
      assert (sb.size() != 0) else begin
        failures++;
        $error("FAIL sb_underflow observed=output expected=no_output");
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        $display("txn out result=%h flags=%b exp_result=%h exp_flags=%b",
                 out_result, out_flags, e[34:3], e[2:0]);
        check("out_result", {32'd0, out_result}, {32'd0, e[34:3]});
        check("out_flags", {61'd0, out_flags}, {61'd0, e[2:0]});
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] er, input logic [2:0] ef);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    exp_cur  = {er, ef};
    tick();
    in_valid = 1'b0;
    in_a     = $urandom;
    in_b     = $urandom;
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (sb.size() == 0 && !out_valid) break;
      tick();
    end
    check("drain_sb_empty", 64'(sb.size()), 64'd0);
    check("drain_out_valid", {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    exp_cur   = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_add_a", {32'd0, add_a}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Idle after reset
    check("idle_in_ready", {63'd0, in_ready}, 64'd1);
    check("idle_out_valid", {63'd0, out_valid}, 64'd0);
    check("idle_count", {61'd0, count}, 64'd0);
    check("idle_add_a", {32'd0, add_a}, 64'd0);
    check("idle_add_b", {32'd0, add_b}, 64'd0);
    check("idle_out_result", {32'd0, out_result}, 64'd0);
    check("idle_out_flags", {61'd0, out_flags}, 64'd0);

    // 4 + 2, latency of one edge after acceptance
    send(32'h40800000, 32'h40000000, 32'h40C00000, 3'b000);
    check("lat_out_valid_low", {63'd0, out_valid}, 64'd0);
    check("lat_count", {61'd0, count}, 64'd1);
    check("lat_add_a", {32'd0, add_a}, 64'h40800000);
    check("lat_add_b", {32'd0, add_b}, 64'h40000000);
    tick();
    check("lat_out_valid_high", {63'd0, out_valid}, 64'd1);
    check("lat_out_result", {32'd0, out_result}, 64'h40C00000);
    drain();

    // 4 + (-2), then +0 + -0
    send(32'h40800000, 32'hC0000000, 32'h40000000, 3'b000);
    send(32'h00000000, 32'h80000000, 32'h00000000, 3'b100);
    drain();

    // Backpressure: five pairs, one in the slot and four queued
    out_ready = 1'b0;
    send(32'h3F800000, 32'h3F800000, 32'h40000000, 3'b000);
    send(32'h3F800000, 32'h40000000, 32'h40400000, 3'b000);
    send(32'h40000000, 32'h40000000, 32'h40800000, 3'b000);
    send(32'h40800000, 32'h3F800000, 32'h40A00000, 3'b000);
    send(32'h40800000, 32'h40000000, 32'h40C00000, 3'b000);
    check("bp_count_full", {61'd0, count}, 64'd4);
    check("bp_in_ready", {63'd0, in_ready}, 64'd0);
    check("bp_out_valid", {63'd0, out_valid}, 64'd1);
    check("bp_frozen_result", {32'd0, out_result}, 64'h40000000);
    check("bp_head_a", {32'd0, add_a}, 64'h3F800000);
    check("bp_head_b", {32'd0, add_b}, 64'h40000000);
    send(32'h41200000, 32'h41200000, 32'h41A00000, 3'b000);
    check("bp_full_reject_count", {61'd0, count}, 64'd4);
    check("bp_still_frozen", {32'd0, out_result}, 64'h40000000);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("tp_out_valid", {63'd0, out_valid}, 64'd1);
      check("tp_count", 64'(4 - i), {61'd0, count});
      tick();
    end
    check("tp_done_valid", {63'd0, out_valid}, 64'd0);
    check("tp_sb_empty", 64'(sb.size()), 64'd0);

    // NaN and Inf classification
    send(32'h7FC00000, 32'h3F800000, 32'h7FC00000, 3'b001);
    send(32'h7F800000, 32'h3F800000, 32'h7F800000, 3'b010);
    drain();

    // Asynchronous reset mid-burst with count=3 and a pending output
    out_ready = 1'b0;
    send(32'h3F800000, 32'h3F800000, 32'h40000000, 3'b000);
    send(32'h40000000, 32'h40000000, 32'h40800000, 3'b000);
    send(32'h40800000, 32'h40000000, 32'h40C00000, 3'b000);
    send(32'h40800000, 32'h3F800000, 32'h40A00000, 3'b000);
    check("pre_rst_count", {61'd0, count}, 64'd3);
    check("pre_rst_out_valid", {63'd0, out_valid}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_count", {61'd0, count}, 64'd0);
    check("arst_out_valid", {63'd0, out_valid}, 64'd0);
    check("arst_out_result", {32'd0, out_result}, 64'd0);
    check("arst_out_flags", {61'd0, out_flags}, 64'd0);
    check("arst_in_ready", {63'd0, in_ready}, 64'd1);
    check("arst_add_a", {32'd0, add_a}, 64'd0);
    check("arst_add_b", {32'd0, add_b}, 64'd0);
    sb.delete();
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("post_rst_count", {61'd0, count}, 64'd0);
    end
    send(32'h40000000, 32'hC0800000, 32'hC0000000, 3'b000);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
